// File: rtl/hazard_scoreboard.sv
// Issue scoreboard: per-register pending-write counters, RAW/WAW stall and issue strobe.
// Optional same-cycle writeback forwarding: define HAZARD_SCOREBOARD_FWD_BYPASS_EN.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid_in,
  input  logic [ADDR_W-1:0] dec_rs1_in,
  input  logic              dec_rs1_read_in,
  input  logic [ADDR_W-1:0] dec_rs2_in,
  input  logic              dec_rs2_read_in,
  input  logic [ADDR_W-1:0] dec_rd_in,
  input  logic              dec_rd_write_in,
  input  logic              ex_ready_in,
  input  logic              wb_valid_in,
  input  logic [ADDR_W-1:0] wb_rd_in,
  input  logic              flush_in,
  output logic              stall_out,
  output logic              issue_out,
  output logic              busy_out,
  output logic              err_underflow_out
);

  localparam int                   DEPTH   = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

  // Index 0 and indices at or beyond NUM_REGS are held at zero, so they never hazard.
  logic [CNT_W-1:0] cnt     [DEPTH];
  logic [CNT_W-1:0] cnt_nxt [DEPTH];

  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic             rs1_pend, rs2_pend, raw_hit, waw_full;
  logic             underflow, busy_nxt;

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] r;
    r = c;
    if (inc && !dec && c != CNT_MAX)
      r = c + CNT_ONE;
    else if (dec && !inc && c != '0)
      r = c - CNT_ONE;
    return r;
  endfunction

  assign cnt_rs1 = cnt[dec_rs1_in];
  assign cnt_rs2 = cnt[dec_rs2_in];
  assign cnt_rd  = cnt[dec_rd_in];
  assign cnt_wb  = cnt[wb_rd_in];

`ifdef HAZARD_SCOREBOARD_FWD_BYPASS_EN
  // A source whose last outstanding write retires this cycle is forwarded, not pending.
  assign rs1_pend = (cnt_rs1 != '0) &&
                    !(wb_valid_in && wb_rd_in == dec_rs1_in && cnt_rs1 == CNT_ONE);
  assign rs2_pend = (cnt_rs2 != '0) &&
                    !(wb_valid_in && wb_rd_in == dec_rs2_in && cnt_rs2 == CNT_ONE);
`else
  assign rs1_pend = (cnt_rs1 != '0);
  assign rs2_pend = (cnt_rs2 != '0);
`endif

  assign raw_hit   = (dec_rs1_read_in && rs1_pend) || (dec_rs2_read_in && rs2_pend);
  assign waw_full  = dec_rd_write_in && (dec_rd_in != '0) && (cnt_rd == CNT_MAX);
  assign stall_out = dec_valid_in && (raw_hit || waw_full || !ex_ready_in || flush_in);
  assign issue_out = dec_valid_in && !stall_out;

  assign underflow = !flush_in && wb_valid_in && (wb_rd_in != '0) && (cnt_wb == '0);

  always_comb begin
    busy_nxt = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_nxt[r] = '0;
      if (r != 0 && r < NUM_REGS && !flush_in)
        cnt_nxt[r] = sat_step(cnt[r],
                              issue_out && dec_rd_write_in && dec_rd_in == ADDR_W'(r),
                              wb_valid_in && wb_rd_in == ADDR_W'(r) && cnt[r] != '0);
      busy_nxt = busy_nxt || (cnt_nxt[r] != '0);
    end
  end

  // Stage boundary: counter state and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= '0;
      busy_out          <= 1'b0;
      err_underflow_out <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= cnt_nxt[r];
      busy_out <= busy_nxt;
      if (underflow) err_underflow_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow the bypass macro setting.
module tb_hazard_scoreboard;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              dec_valid_in, dec_rs1_read_in, dec_rs2_read_in, dec_rd_write_in;
  logic [ADDR_W-1:0] dec_rs1_in, dec_rs2_in, dec_rd_in, wb_rd_in;
  logic              ex_ready_in, wb_valid_in, flush_in;
  logic              stall_out, issue_out, busy_out, err_underflow_out;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef HAZARD_SCOREBOARD_FWD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  hazard_scoreboard #(.NUM_REGS(32), .ADDR_W(ADDR_W), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .dec_valid_in(dec_valid_in), .dec_rs1_in(dec_rs1_in), .dec_rs1_read_in(dec_rs1_read_in),
    .dec_rs2_in(dec_rs2_in), .dec_rs2_read_in(dec_rs2_read_in),
    .dec_rd_in(dec_rd_in), .dec_rd_write_in(dec_rd_write_in),
    .ex_ready_in(ex_ready_in), .wb_valid_in(wb_valid_in), .wb_rd_in(wb_rd_in),
    .flush_in(flush_in), .stall_out(stall_out), .issue_out(issue_out),
    .busy_out(busy_out), .err_underflow_out(err_underflow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid_in = 0; dec_rs1_read_in = 0; dec_rs2_read_in = 0; dec_rd_write_in = 0;
    dec_rs1_in = 0; dec_rs2_in = 0; dec_rd_in = 0;
    ex_ready_in = 1; wb_valid_in = 0; wb_rd_in = 0; flush_in = 0;
  endtask

  task automatic writer(input logic [ADDR_W-1:0] rd);
    dec_valid_in = 1; dec_rd_write_in = 1; dec_rd_in = rd;
    dec_rs1_read_in = 0; dec_rs2_read_in = 0;
  endtask

  task automatic reader1(input logic [ADDR_W-1:0] rs);
    dec_valid_in = 1; dec_rd_write_in = 0; dec_rs1_read_in = 1; dec_rs1_in = rs;
    dec_rs2_read_in = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_stall", stall_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_err", err_underflow_out, 0);

    // RAW on r5 with writeback release
    writer(5); #1;
    chk("a_issue_w5", issue_out, 1);
    tick();
    chk("a_busy", busy_out, 1);
    reader1(5); #1;
    chk("a_raw_stall", stall_out, 1);
    chk("a_raw_noissue", issue_out, 0);
    tick();
    wb_valid_in = 1; wb_rd_in = 5; #1;
    chk("a_wb_stall", stall_out, !BYP);
    chk("a_wb_issue", issue_out, BYP);
    tick();
    wb_valid_in = 0; #1;
    chk("a_after_wb_issue", issue_out, 1);
    tick();
    chk("a_busy_clear", busy_out, 0);
    chk("a_no_err", err_underflow_out, 0);

    // Source index 0 and rd 0; ex_ready backpressure
    dec_valid_in = 1; dec_rs1_read_in = 1; dec_rs1_in = 0; dec_rd_write_in = 1; dec_rd_in = 0; #1;
    chk("z_issue_r0", issue_out, 1);
    tick();
    chk("z_busy_r0", busy_out, 0);
    idle(); dec_valid_in = 1; ex_ready_in = 0; #1;
    chk("x_ex_stall", stall_out, 1);
    chk("x_ex_noissue", issue_out, 0);
    idle(); #1;

    // WAW saturation on r7
    writer(7); tick(); tick(); tick();
    #1;
    chk("b_waw_stall", stall_out, 1);
    tick();
    chk("b_waw_hold", stall_out, 1);
    wb_valid_in = 1; wb_rd_in = 7; #1;
    chk("b_wb_still_stall", stall_out, 1);
    tick();
    wb_valid_in = 0; #1;
    chk("b_fourth_issue", issue_out, 1);
    tick();
    writer(7); #1;
    chk("b_full_again", stall_out, 1);
    idle(); wb_valid_in = 1; wb_rd_in = 7;
    tick(); tick();
    wb_valid_in = 0;
    dec_valid_in = 1; dec_rs2_read_in = 1; dec_rs2_in = 7; #1;
    chk("b_rs2_pending", stall_out, 1);
    idle(); wb_valid_in = 1; wb_rd_in = 7;
    tick();
    idle(); #1;
    chk("b_drained_busy", busy_out, 0);
    chk("b_drained_err", err_underflow_out, 0);

    // Simultaneous issue and writeback on r9
    writer(9); tick();
    wb_valid_in = 1; wb_rd_in = 9; #1;
    chk("c_issue_with_wb", issue_out, 1);
    tick();
    idle(); #1;
    chk("c_busy", busy_out, 1);
    reader1(9); #1;
    chk("c_still_pending", stall_out, 1);
    idle(); wb_valid_in = 1; wb_rd_in = 9;
    tick();
    idle(); #1;
    chk("c_cnt_was_one", busy_out, 0);
    chk("c_no_err", err_underflow_out, 0);

    // Flush with r3 pending twice; writeback during flush is ignored
    writer(3); tick(); tick();
    flush_in = 1; wb_valid_in = 1; wb_rd_in = 12; #1;
    chk("d_flush_noissue", issue_out, 0);
    chk("d_flush_stall", stall_out, 1);
    tick();
    idle(); #1;
    chk("d_flush_busy", busy_out, 0);
    chk("d_flush_no_err", err_underflow_out, 0);
    reader1(3); #1;
    chk("d_r3_clear", issue_out, 1);
    idle();

    // Underflow flag
    wb_valid_in = 1; wb_rd_in = 0;
    tick();
    chk("e_wb0_no_err", err_underflow_out, 0);
    wb_rd_in = 12;
    tick();
    idle();
    chk("e_underflow", err_underflow_out, 1);
    tick();
    chk("e_sticky", err_underflow_out, 1);
    chk("e_busy", busy_out, 0);

    // Reset overrides a same-cycle issue
    writer(4); reset = 1;
    tick();
    reset = 0; idle(); #1;
    chk("f_rst_err", err_underflow_out, 0);
    chk("f_rst_busy", busy_out, 0);
    tick();
    chk("f_rst_no_inc", busy_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
